output_mem_bank_router: RTL and testbench
=========================================

// Module: output_mem_bank_router
// PURPOSE
//  Parametrised successor to the output-memory address decoder.
//  Routes psum-controller read/write requests to NUM_MEM BRAM controllers, selected by address bits [MEM_ADDR_WIDTH +: NUM_MEM_WIDTH].
//  Tracks outstanding reads in an in-order tag FIFO so returned data is matched to the issuing bank under any read latency.
//  Applies read back-pressure, drops out-of-range accesses and flags protocol errors.
// PARAMETERS
//  ADDR_WIDTH      32  psum/bram address width
//  DATA_WIDTH      32  read data width
//  MEM_ADDR_WIDTH  15  word address bits inside one bank
//  NUM_MEM_WIDTH   2   bank-select bits; NUM_MEM = 1<<NUM_MEM_WIDTH banks
//  TAG_DEPTH       4   max outstanding reads (power of 2, >=2)
// PORTS
//  clk                 in   1                    clock, all logic on posedge
//  rst                 in   1                    asynchronous reset, active-high
//  psumctrl_wadd       in   ADDR_WIDTH           write address
//  psumctrl_wren       in   1                    write enable
//  psumctrl_radd       in   ADDR_WIDTH           read address
//  psumctrl_rden       in   1                    read request
//  psumctrl_rrdy       out  1                    read accepted when rden&rrdy
//  psumctrl_odat       out  DATA_WIDTH           read data
//  psumctrl_ovld       out  1                    read data valid
//  psumctrl_err        out  1                    sticky error flag
//  psumctrl_err_clr    in   1                    clears psumctrl_err
//  bramctrl_addr_rd    out  NUM_MEM*ADDR_WIDTH   per-bank read addr, bank i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  bramctrl_rden_rd    out  NUM_MEM              per-bank read enable
//  bramctrl_odat_rd    in   NUM_MEM*DATA_WIDTH   per-bank read data
//  bramctrl_oval_rd    in   NUM_MEM              per-bank read data valid
//  bramctrl_addr_wr    out  NUM_MEM*ADDR_WIDTH   per-bank write addr
//  bramctrl_wren_wr    out  NUM_MEM              per-bank write enable
// BEHAVIOUR
//  - Reset: odat=0, ovld=0, err=0, tag FIFO empty (count=0, pointers 0), rrdy=1.
//    Reset mid-operation discards all outstanding tags.
//  - Range check: the address is in range iff bits above MEM_ADDR_WIDTH+NUM_MEM_WIDTH-1 are all 0.
//  - Write path (combinational, 0 latency):
//    - Selected bank gets {0, wadd[MEM_ADDR_WIDTH-1:0]} and wren.
//    - All other banks get addr=0, wren=0.
//    - Out-of-range write: no bank enabled; err set next cycle.
//  - Read path (combinational issue):
//    - rrdy = (count != TAG_DEPTH), derived from registered count only.
//    - An accepted in-range read drives the selected bank's addr/rden, and its bank index is pushed into the tag FIFO.
//    - Non-selected banks get addr=0, rden=0.
//    - While rrdy=0, every bank rden=0.
//    - Out-of-range accepted read: nothing issued, no tag pushed, err set, ovld never produced for it.
//  - Return path (1-cycle latency):
//    - When oval_rd[head] is 1, next cycle odat=odat_rd[head] and ovld=1; the head tag is popped.
//    - Otherwise ovld=0 and odat holds its value.
//    - oval from a non-head bank, or any oval while the FIFO is empty: data dropped, err set.
//  - Simultaneous push and pop: count unchanged, both pointers advance.
//    A pop when full raises rrdy the following cycle (no same-cycle pass-through).
//  - Pointers wrap modulo TAG_DEPTH.
//  - err is sticky until err_clr. err_clr has priority over a new error in the same cycle; an error in the next cycle sets err again.
// CONFIGURATION
//  OUTPUT_MEM_ROUTER_ERRCNT_EN
//    - Defined: adds output psumctrl_err_cnt [15:0], a saturating count of dropped accesses (range errors plus orphan/misordered returns).
//      One increment per cycle even if two errors occur in that cycle. Reset to 0; cleared by err_clr; holds at 16'hFFFF.
//    - Undefined: the port is absent; only the sticky err flag exists.
// TESTING
//  1 Write: wadd=0x0000_8005, wren=1 -> wren_wr=4'b0010, bank1 addr=0x5, other banks addr=0, err=0.
//  2 Read: radd=0x0001_0010, rden=1; bank2 oval two cycles later with odat=0xCAFE -> ovld=1, odat=0xCAFE one cycle after oval.
//  3 Ordering: reads to banks 3,0,1 back-to-back, returns in order -> three ovld pulses, data in issue order, count returns to 0.
//  4 Back-pressure: 4 reads with no returns -> rrdy=0 on the 5th cycle and no rden issued.
//    One return -> rrdy=1 the cycle after the pop.
//  5 Errors: radd=0x0002_0000 -> no rden, err=1, no ovld.
//    Spurious oval_rd[2] with empty FIFO -> err stays 1; err_clr -> err=0.
//    With ERRCNT_EN: cnt=2, then 0.
//  6 Reset with 2 outstanding reads -> count=0, ovld=0; late oval afterwards -> dropped, err=1.

Source files
------------

// File: rtl/output_mem_bank_router.sv
// Routes psum-controller reads/writes to NUM_MEM BRAM banks; an in-order tag FIFO matches read returns to banks.
// Optional macro OUTPUT_MEM_ROUTER_ERRCNT_EN adds the saturating psumctrl_err_cnt output.
module output_mem_bank_router #(
    parameter  int ADDR_WIDTH     = 32,
    parameter  int DATA_WIDTH     = 32,
    parameter  int MEM_ADDR_WIDTH = 15,
    parameter  int NUM_MEM_WIDTH  = 2,
    parameter  int TAG_DEPTH      = 4,
    localparam int NUM_MEM        = 1 << NUM_MEM_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_WIDTH-1:0]         psumctrl_wadd,
    input  logic                          psumctrl_wren,
    input  logic [ADDR_WIDTH-1:0]         psumctrl_radd,
    input  logic                          psumctrl_rden,
    output logic                          psumctrl_rrdy,
    output logic [DATA_WIDTH-1:0]         psumctrl_odat,
    output logic                          psumctrl_ovld,
`ifdef OUTPUT_MEM_ROUTER_ERRCNT_EN
    output logic [15:0]                   psumctrl_err_cnt,
`endif
    output logic                          psumctrl_err,
    input  logic                          psumctrl_err_clr,
    output logic [NUM_MEM*ADDR_WIDTH-1:0] bramctrl_addr_rd,
    output logic [NUM_MEM-1:0]            bramctrl_rden_rd,
    input  logic [NUM_MEM*DATA_WIDTH-1:0] bramctrl_odat_rd,
    input  logic [NUM_MEM-1:0]            bramctrl_oval_rd,
    output logic [NUM_MEM*ADDR_WIDTH-1:0] bramctrl_addr_wr,
    output logic [NUM_MEM-1:0]            bramctrl_wren_wr
);

    localparam int HI_LSB = MEM_ADDR_WIDTH + NUM_MEM_WIDTH;
    localparam int PTR_W  = $clog2(TAG_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef logic [NUM_MEM_WIDTH-1:0] bank_t;

    logic               w_wr_in_range;
    logic               w_rd_in_range;
    bank_t              w_wr_bank;
    bank_t              w_rd_bank;
    logic               w_rd_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_fifo_empty;
    bank_t              w_head;
    logic [NUM_MEM-1:0] w_head_mask;
    logic               w_wr_err;
    logic               w_rd_err;
    logic               w_ret_err;
    logic               w_any_err;

    bank_t              r_tag [TAG_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [DATA_WIDTH-1:0] r_odat;
    logic               r_ovld;
    logic               r_err;

    // An address is legal only when every bit above the bank-select field is zero.
    assign w_wr_in_range = (psumctrl_wadd >> HI_LSB) == '0;
    assign w_rd_in_range = (psumctrl_radd >> HI_LSB) == '0;
    assign w_wr_bank     = psumctrl_wadd[MEM_ADDR_WIDTH +: NUM_MEM_WIDTH];
    assign w_rd_bank     = psumctrl_radd[MEM_ADDR_WIDTH +: NUM_MEM_WIDTH];

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        bramctrl_addr_wr = '0;
        bramctrl_wren_wr = '0;
        if (w_wr_in_range) begin
            bramctrl_addr_wr[int'(w_wr_bank)*ADDR_WIDTH +: ADDR_WIDTH] =
                ADDR_WIDTH'(psumctrl_wadd[MEM_ADDR_WIDTH-1:0]);
            bramctrl_wren_wr[w_wr_bank] = psumctrl_wren;
        end
    end

    assign psumctrl_rrdy = (r_count != CNT_W'(TAG_DEPTH));
    assign w_rd_accept   = psumctrl_rden && psumctrl_rrdy;
    assign w_push        = w_rd_accept && w_rd_in_range;

    always_comb begin
        bramctrl_addr_rd = '0;
        bramctrl_rden_rd = '0;
        if (w_push) begin
            bramctrl_addr_rd[int'(w_rd_bank)*ADDR_WIDTH +: ADDR_WIDTH] =
                ADDR_WIDTH'(psumctrl_radd[MEM_ADDR_WIDTH-1:0]);
            bramctrl_rden_rd[w_rd_bank] = 1'b1;
        end
    end

    // Only the bank at the FIFO head may return data; anything else is an orphan.
    assign w_fifo_empty = (r_count == '0);
    assign w_head       = r_tag[r_rd_ptr];

    always_comb begin
        w_head_mask = '0;
        if (!w_fifo_empty) begin
            w_head_mask[w_head] = 1'b1;
        end
    end

    assign w_pop     = |(bramctrl_oval_rd & w_head_mask);
    assign w_ret_err = |(bramctrl_oval_rd & ~w_head_mask);
    assign w_wr_err  = psumctrl_wren && !w_wr_in_range;
    assign w_rd_err  = w_rd_accept && !w_rd_in_range;
    assign w_any_err = w_wr_err || w_rd_err || w_ret_err;

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: tag storage is left unreset; r_count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag[r_wr_ptr] <= w_rd_bank;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_odat <= '0;
            r_ovld <= 1'b0;
        end else begin
            r_ovld <= w_pop;
            if (w_pop) begin
                r_odat <= bramctrl_odat_rd[int'(w_head)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Clear wins over a coincident error; a later error sets the flag again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (psumctrl_err_clr) begin
            r_err <= 1'b0;
        end else if (w_any_err) begin
            r_err <= 1'b1;
        end
    end

`ifdef OUTPUT_MEM_ROUTER_ERRCNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (psumctrl_err_clr) begin
            r_err_cnt <= '0;
        end else if (w_any_err && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign psumctrl_err_cnt = r_err_cnt;
`endif

    assign psumctrl_odat = r_odat;
    assign psumctrl_ovld = r_ovld;
    assign psumctrl_err  = r_err;

endmodule

// File: tb/tb_output_mem_bank_router.sv
// Directed bench for output_mem_bank_router: expected read data is queued at issue and compared on ovld.
// Build with OUTPUT_MEM_ROUTER_ERRCNT_EN defined to also cover psumctrl_err_cnt.
module tb_output_mem_bank_router;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MAW = 15;
    localparam int NMW = 2;
    localparam int NM  = 4;
    localparam int TD  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [AW-1:0]    wadd;
    logic             wren;
    logic [AW-1:0]    radd;
    logic             rden;
    logic             rrdy;
    logic [DW-1:0]    odat;
    logic             ovld;
    logic             err;
    logic             err_clr;
    logic [NM*AW-1:0] addr_rd;
    logic [NM-1:0]    rden_rd;
    logic [NM*DW-1:0] odat_rd;
    logic [NM-1:0]    oval_rd;
    logic [NM*AW-1:0] addr_wr;
    logic [NM-1:0]    wren_wr;
`ifdef OUTPUT_MEM_ROUTER_ERRCNT_EN
    logic [15:0]      err_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_ovld   = 0;
    logic [DW-1:0] exp_q [$];

    output_mem_bank_router #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_ADDR_WIDTH(MAW),
        .NUM_MEM_WIDTH(NMW), .TAG_DEPTH(TD)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .psumctrl_wadd    (wadd),
        .psumctrl_wren    (wren),
        .psumctrl_radd    (radd),
        .psumctrl_rden    (rden),
        .psumctrl_rrdy    (rrdy),
        .psumctrl_odat    (odat),
        .psumctrl_ovld    (ovld),
`ifdef OUTPUT_MEM_ROUTER_ERRCNT_EN
        .psumctrl_err_cnt (err_cnt),
`endif
        .psumctrl_err     (err),
        .psumctrl_err_clr (err_clr),
        .bramctrl_addr_rd (addr_rd),
        .bramctrl_rden_rd (rden_rd),
        .bramctrl_odat_rd (odat_rd),
        .bramctrl_oval_rd (oval_rd),
        .bramctrl_addr_wr (addr_wr),
        .bramctrl_wren_wr (wren_wr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every ovld pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ovld === 1'b1) begin
            n_ovld++;
            check("sb_pending", 128'(exp_q.size() != 0), 128'd1);
            if (exp_q.size() != 0) begin
                check("sb_odat", 128'(odat), 128'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [DW-1:0] rd_data(input int bank, input int waddr);
        return 32'hD000_0000 | 32'(bank << 20) | 32'(waddr);
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        wadd    = '0;
        wren    = 1'b0;
        radd    = '0;
        rden    = 1'b0;
        err_clr = 1'b0;
        oval_rd = '0;
        odat_rd = '0;
    endtask

    task automatic issue_read(input int bank, input int waddr, input logic [DW-1:0] data, input string tag);
        radd = (32'(bank) << MAW) | 32'(waddr);
        rden = 1'b1;
        #1;
        check({tag, "_rrdy"}, 128'(rrdy), 128'd1);
        check({tag, "_rden"}, 128'(rden_rd), 128'(4'b0001 << bank));
        check({tag, "_addr"}, 128'(addr_rd), 128'(waddr) << (bank * AW));
        exp_q.push_back(data);
    endtask

    task automatic ret(input int bank, input logic [DW-1:0] data);
        oval_rd       = '0;
        odat_rd       = '0;
        oval_rd[bank] = 1'b1;
        odat_rd[bank*DW +: DW] = data;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_ovld", 128'(ovld), 128'd0);
        check("rst_odat", 128'(odat), 128'd0);
        check("rst_err", 128'(err), 128'd0);
        check("rst_rrdy", 128'(rrdy), 128'd1);
        check("rst_rden", 128'(rden_rd), 128'd0);
`ifdef OUTPUT_MEM_ROUTER_ERRCNT_EN
        check("rst_cnt", 128'(err_cnt), 128'd0);
`endif

        // Write decode
        tick();
        wadd = 32'h0000_8005;
        wren = 1'b1;
        #1;
        check("wr_wren", 128'(wren_wr), 128'(4'b0010));
        check("wr_addr", 128'(addr_wr), 128'h5 << AW);
        tick();
        idle();
        #1;
        check("wr_err", 128'(err), 128'd0);
        check("wr_idle", 128'(wren_wr), 128'd0);

        // Single read, bank 2, returned two cycles after issue
        tick();
        issue_read(2, 'h10, 32'h0000_CAFE, "rd");
        tick();
        idle();
        #1;
        check("rd_rden_off", 128'(rden_rd), 128'd0);
        tick();
        ret(2, 32'h0000_CAFE);
        tick();
        idle();
        #1;
        check("rd_ovld", 128'(ovld), 128'd1);
        tick();
        #1;
        check("rd_ovld_off", 128'(ovld), 128'd0);
        check("rd_odat_hold", 128'(odat), 128'h0000_CAFE);

        // Back-to-back reads to banks 3,0,1 returned in order
        tick(); issue_read(3, 1, rd_data(3, 1), "ord0");
        tick(); issue_read(0, 2, rd_data(0, 2), "ord1");
        tick(); issue_read(1, 3, rd_data(1, 3), "ord2");
        tick(); idle(); ret(3, rd_data(3, 1));
        tick(); ret(0, rd_data(0, 2));
        tick(); ret(1, rd_data(1, 3));
        tick(); idle();
        tick();
        #1;
        check("ord_drained", 128'(exp_q.size()), 128'd0);
        check("ord_rrdy", 128'(rrdy), 128'd1);

        // Back-pressure: four outstanding reads fill the tag FIFO
        for (int i = 0; i < TD; i++) begin
            tick();
            issue_read(i, 'h40 + i, rd_data(i, 'h40 + i), "bp");
        end
        tick();
        radd = 32'h0001_0044;
        rden = 1'b1;
        #1;
        check("bp_full_rrdy", 128'(rrdy), 128'd0);
        check("bp_full_rden", 128'(rden_rd), 128'd0);
        tick();
        idle();
        ret(0, rd_data(0, 'h40));
        #1;
        check("bp_pop_rrdy", 128'(rrdy), 128'd0);
        tick();
        idle();
        #1;
        check("bp_after_pop_rrdy", 128'(rrdy), 128'd1);
        // Push and pop together: occupancy stays at three
        issue_read(0, 'h50, rd_data(0, 'h50), "bp_pp");
        ret(1, rd_data(1, 'h41));
        tick();
        idle();
        #1;
        check("bp_pp_rrdy", 128'(rrdy), 128'd1);
        ret(2, rd_data(2, 'h42));
        tick(); ret(3, rd_data(3, 'h43));
        tick(); ret(0, rd_data(0, 'h50));
        tick(); idle();
        tick();
        #1;
        check("bp_drained", 128'(exp_q.size()), 128'd0);

        // Errors: out-of-range read, orphan return, clear
        tick();
        radd = 32'h0002_0000;
        rden = 1'b1;
        #1;
        check("err_rd_rrdy", 128'(rrdy), 128'd1);
        check("err_rd_rden", 128'(rden_rd), 128'd0);
        tick();
        idle();
        ret(2, 32'h0000_BAD0);
        #1;
        check("err_rd_err", 128'(err), 128'd1);
`ifdef OUTPUT_MEM_ROUTER_ERRCNT_EN
        check("err_rd_cnt", 128'(err_cnt), 128'd1);
`endif
        tick();
        idle();
        #1;
        check("err_orphan_err", 128'(err), 128'd1);
        check("err_orphan_ovld", 128'(ovld), 128'd0);
`ifdef OUTPUT_MEM_ROUTER_ERRCNT_EN
        check("err_orphan_cnt", 128'(err_cnt), 128'd2);
`endif
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        #1;
        check("err_clr_err", 128'(err), 128'd0);
`ifdef OUTPUT_MEM_ROUTER_ERRCNT_EN
        check("err_clr_cnt", 128'(err_cnt), 128'd0);
`endif
        // Clear beats a coincident out-of-range write; the next one sets err again
        err_clr = 1'b1;
        wadd    = 32'h4000_0000;
        wren    = 1'b1;
        #1;
        check("err_oor_wren", 128'(wren_wr), 128'd0);
        tick();
        err_clr = 1'b0;
        #1;
        check("err_prio_err", 128'(err), 128'd0);
        ret(1, 32'h0000_BAD1);
        tick();
        idle();
        #1;
        check("err_reset_err", 128'(err), 128'd1);
`ifdef OUTPUT_MEM_ROUTER_ERRCNT_EN
        check("err_two_in_cycle_cnt", 128'(err_cnt), 128'd1);
`endif
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        #1;
        check("err_clr2_err", 128'(err), 128'd0);

        // Reset with two outstanding reads, then a late return
        tick(); issue_read(1, 7, rd_data(1, 7), "rst_rd0");
        tick(); issue_read(2, 8, rd_data(2, 8), "rst_rd1");
        tick();
        idle();
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_ovld", 128'(ovld), 128'd0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_rrdy", 128'(rrdy), 128'd1);
        check("post_rst_err", 128'(err), 128'd0);
        ret(1, rd_data(1, 7));
        tick();
        idle();
        #1;
        check("late_ret_err", 128'(err), 128'd1);
        check("late_ret_ovld", 128'(ovld), 128'd0);
        tick();
        issue_read(3, 9, rd_data(3, 9), "post_rst_rd");
        tick();
        idle();
        ret(3, rd_data(3, 9));
        tick();
        idle();
        #1;
        check("post_rst_ovld", 128'(ovld), 128'd1);
        tick();
        tick();
        #1;
        check("final_drained", 128'(exp_q.size()), 128'd0);
        check("final_ovld_count", 128'(n_ovld), 128'd10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
